bus_cycle_controller: RTL
=========================

# bus_cycle_controller

Sequences every 68000 bus cycle against the regions selected by the address decoder and generates the processor handshake. It terminates each cycle with DTACK_L or BERR_L: after a per-region number of wait states for on-chip ROM, on-chip RAM and IO, or after an external acknowledge for DRAM and CAN bus. It sits between the CPU strobes (AS_L, UDS_L, LDS_L), the decoder's select outputs and the CPU's DTACK_L/BERR_L inputs.

## Interface
- ROM_WAIT, 1, wait states for on-chip ROM cycles (0..15)
- RAM_WAIT, 1, wait states for on-chip RAM cycles (0..15)
- IO_WAIT, 2, wait states for IO cycles (0..15)
- TIMEOUT_CYCLES, 255, clocks from cycle start to bus error (1..65535)

- Clock  in  1  system clock; all state changes on rising edge
- Reset_L  in  1  synchronous active-low reset
- AS_L  in  1  CPU address strobe
- UDS_L, LDS_L  in  1 each  CPU data strobes
- OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, DramSelect_H, CanBusSelect_H  in  1 each  decoder selects
- DramDtack_L  in  1  DRAM controller acknowledge
- CanBusDtack_L  in  1  CAN controller acknowledge
- DTACK_L  out  1  registered data acknowledge to CPU
- BERR_L  out  1  registered bus error to CPU
- CycleActive_H  out  1  high in every state except IDLE
- Timeout_H  out  1  sticky flag, set on any bus error, cleared only by reset

## Operation
- States: IDLE, WAIT, EXT, ACK, BERR.
- Start: in IDLE, AS_L=0 and (UDS_L=0 or LDS_L=0) sampled → region latched, timeout counter cleared to 0.
- Region priority when several selects are high: ROM > RAM > IO > DRAM > CAN. None high → unmapped.
- ROM/RAM/IO → WAIT with wait counter loaded from the matching parameter. DRAM/CAN → EXT. Unmapped → EXT with no acknowledge source.
- WAIT: decrement each clock. Counter 0 → ACK.
- EXT: selected *Dtack_L sampled low → ACK.
- Timeout counter: 16 bits, increments each clock in WAIT/EXT, saturates. Reaching TIMEOUT_CYCLES in EXT → BERR. WAIT never times out.
- Acknowledge and timeout on the same edge: acknowledge wins.
- ACK: DTACK_L=0. BERR: BERR_L=0, Timeout_H set. Both hold until AS_L sampled high → IDLE, strobe released on that same edge.
- AS_L sampled high in WAIT/EXT (aborted cycle) → IDLE, no acknowledge issued.
- Reset_L=0 in any state → IDLE on that edge.
- Reset values: DTACK_L=1, BERR_L=1, CycleActive_H=0, Timeout_H=0, state IDLE, counters 0.

## Timing
- Inputs sampled on the rising edge. Outputs registered, with no combinational path from input to output.
- Edge 0 = start edge. A WAIT region with W wait states drives DTACK_L low after edge W+1. W=0 gives DTACK_L low after edge 1.
- EXT: acknowledge sampled low at edge k → DTACK_L low after edge k+1.
- Timeout: BERR_L low after edge TIMEOUT_CYCLES+1.
- Release: AS_L sampled high at edge r → DTACK_L/BERR_L high and CycleActive_H low after edge r.
- A new cycle can start no earlier than the edge after returning to IDLE.
- Selects are used only at edge 0. Later changes are ignored.

## Configuration
- BUS_TIMEOUT_EN defined: timeout counter, BERR state and Timeout_H behave as above.
- BUS_TIMEOUT_EN undefined:
  - Timeout counter and BERR state are removed.
  - BERR_L is tied 1 and Timeout_H is tied 0.
  - Unmapped cycles go directly to ACK (DTACK_L low after edge 1).
  - DRAM/CAN cycles wait indefinitely for their acknowledge.

## Test plan
- ROM read, ROM_WAIT=1: AS_L/UDS_L low at edge 0 with OnChipRomSelect_H=1 → DTACK_L low after edge 2; AS_L high at edge 6 → DTACK_L high after edge 6, CycleActive_H=0.
- DRAM write: DramSelect_H=1, DramDtack_L low at edge 5 → DTACK_L low after edge 6, BERR_L stays 1.
- Unmapped, TIMEOUT_CYCLES=8, BUS_TIMEOUT_EN defined → BERR_L low after edge 9, Timeout_H=1 and still 1 after the next good cycle. Without the macro → DTACK_L low after edge 1.
- Priority: RAM and DRAM selects both high, RAM_WAIT=0 → DTACK_L after edge 1; DramDtack_L ignored.
- Abort and reset: AS_L high at edge 2 of an IO_WAIT=4 cycle → IDLE, DTACK_L never low. Reset_L=0 during ACK → DTACK_L=1 after that edge.
- Same-edge collision: CAN cycle, TIMEOUT_CYCLES=4, CanBusDtack_L low at edge 4 → DTACK_L low, BERR_L stays 1, Timeout_H=0.

Source files
------------

// File: rtl/bus_cycle_controller_if.sv
// CPU/decoder-side handshake bundle for bus_cycle_controller: strobes, region
// selects, external acknowledges and the CPU-facing termination outputs.
interface bus_cycle_controller_if;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic IOSelect_H;
  logic DramSelect_H;
  logic CanBusSelect_H;
  logic DramDtack_L;
  logic CanBusDtack_L;
  logic DTACK_L;
  logic BERR_L;
  logic CycleActive_H;
  logic Timeout_H;

  modport master (
    output AS_L, UDS_L, LDS_L,
    output OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, DramSelect_H, CanBusSelect_H,
    output DramDtack_L, CanBusDtack_L,
    input  DTACK_L, BERR_L, CycleActive_H, Timeout_H
  );

  modport slave (
    input  AS_L, UDS_L, LDS_L,
    input  OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, DramSelect_H, CanBusSelect_H,
    input  DramDtack_L, CanBusDtack_L,
    output DTACK_L, BERR_L, CycleActive_H, Timeout_H
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// 68000 bus cycle sequencer: terminates each cycle with DTACK_L after wait states
// or an external acknowledge. Bus-error timeout enabled by macro BUS_TIMEOUT_EN.
module bus_cycle_controller #(
  parameter int unsigned ROM_WAIT       = 1,
  parameter int unsigned RAM_WAIT       = 1,
  parameter int unsigned IO_WAIT        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    Clock,
  input logic                    Reset_L,
  bus_cycle_controller_if.slave  bus
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TMO_W  = 16;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXT, S_ACK, S_BERR} state_t;
  typedef enum logic [2:0] {R_ROM, R_RAM, R_IO, R_DRAM, R_CAN, R_NONE} region_t;

  state_t              r_state;
  region_t             r_region;
  logic [WAIT_W-1:0]   r_wcnt;
  logic                r_ext_ack_l;
  logic                r_dtack_l;
  logic                r_cycle_active;

  logic                w_start;
  region_t             w_region;
  logic                w_ext_ack_l;

  assign w_start = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);

  // Fixed-priority region decode: ROM > RAM > IO > DRAM > CAN
  always_comb begin
    w_region = R_NONE;
    if (bus.OnChipRomSelect_H)      w_region = R_ROM;
    else if (bus.OnChipRamSelect_H) w_region = R_RAM;
    else if (bus.IOSelect_H)        w_region = R_IO;
    else if (bus.DramSelect_H)      w_region = R_DRAM;
    else if (bus.CanBusSelect_H)    w_region = R_CAN;
  end

  always_comb begin
    w_ext_ack_l = 1'b1;
    case (r_region)
      R_DRAM:  w_ext_ack_l = bus.DramDtack_L;
      R_CAN:   w_ext_ack_l = bus.CanBusDtack_L;
      default: w_ext_ack_l = 1'b1;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  logic [TMO_W-1:0] r_tcnt;
  logic             r_berr_l;
  logic             r_timeout;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tcnt >= TMO_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TMO_W'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      r_state        <= S_IDLE;
      r_region       <= R_NONE;
      r_wcnt         <= '0;
      r_ext_ack_l    <= 1'b1;
      r_dtack_l      <= 1'b1;
      r_cycle_active <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_tcnt         <= '0;
      r_berr_l       <= 1'b1;
      r_timeout      <= 1'b0;
`endif
    end else begin
      // External acknowledge is registered once before the FSM acts on it
      r_ext_ack_l <= (r_state == S_EXT) ? w_ext_ack_l : 1'b1;
`ifdef BUS_TIMEOUT_EN
      if ((r_state == S_WAIT || r_state == S_EXT) && (r_tcnt != '1))
        r_tcnt <= r_tcnt + TMO_W'(1);
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_region       <= w_region;
            r_cycle_active <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            r_tcnt         <= '0;
`endif
            case (w_region)
              R_ROM: begin r_wcnt <= WAIT_W'(ROM_WAIT); r_state <= S_WAIT; end
              R_RAM: begin r_wcnt <= WAIT_W'(RAM_WAIT); r_state <= S_WAIT; end
              R_IO:  begin r_wcnt <= WAIT_W'(IO_WAIT);  r_state <= S_WAIT; end
              R_DRAM, R_CAN: r_state <= S_EXT;
              default: begin
`ifdef BUS_TIMEOUT_EN
                r_state <= S_EXT;
`else
                // Without a timeout an unmapped cycle is acknowledged immediately
                r_wcnt  <= '0;
                r_state <= S_WAIT;
`endif
              end
            endcase
          end
        end
        S_WAIT: begin
          if (bus.AS_L) begin
            r_state        <= S_IDLE;
            r_cycle_active <= 1'b0;
          end else if (r_wcnt == '0) begin
            r_state   <= S_ACK;
            r_dtack_l <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt - WAIT_W'(1);
          end
        end
        S_EXT: begin
          if (bus.AS_L) begin
            r_state        <= S_IDLE;
            r_cycle_active <= 1'b0;
          end else if (!r_ext_ack_l) begin
            r_state   <= S_ACK;
            r_dtack_l <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          end else if (w_tmo_hit) begin
            r_state   <= S_BERR;
            r_berr_l  <= 1'b0;
            r_timeout <= 1'b1;
`endif
          end
        end
        S_ACK: begin
          if (bus.AS_L) begin
            r_state        <= S_IDLE;
            r_dtack_l      <= 1'b1;
            r_cycle_active <= 1'b0;
          end
        end
`ifdef BUS_TIMEOUT_EN
        S_BERR: begin
          if (bus.AS_L) begin
            r_state        <= S_IDLE;
            r_berr_l       <= 1'b1;
            r_cycle_active <= 1'b0;
          end
        end
`endif
        default: begin
          r_state        <= S_IDLE;
          r_dtack_l      <= 1'b1;
          r_cycle_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DTACK_L       = r_dtack_l;
  assign bus.CycleActive_H = r_cycle_active;
`ifdef BUS_TIMEOUT_EN
  assign bus.BERR_L        = r_berr_l;
  assign bus.Timeout_H     = r_timeout;
`else
  assign bus.BERR_L        = 1'b1;
  assign bus.Timeout_H     = 1'b0;
`endif

endmodule
